// File: rtl/fp_pkg.sv
// binary32 field layout and constants shared by the accumulate tree and its adder.
package fp_pkg;
  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int FW   = 1 + EW + MW;
  localparam int BIAS = 127;

  localparam logic [EW-1:0] EXP_MAX = '1;
  localparam logic [FW-1:0] QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] man;
  } fp_t;
endpackage

// File: rtl/fp_add.sv
// Combinational binary32 adder: round-to-nearest-even, subnormals flushed to signed zero.
module fp_add
  import fp_pkg::*;
(
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic [FW-1:0] y
);
  fp_t               ua, ub, x, z;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, sub;
  logic [EW-1:0]     d;
  logic [4:0]        dc, lz;
  logic [26:0]       mx, mz, ms, nrm;
  logic [53:0]       sh;
  logic [27:0]       sum;
  logic [23:0]       rnd;
  logic signed [9:0] e;

  assign ua = a;
  assign ub = b;

  always_comb begin
    a_nan  = (ua.exp == EXP_MAX) && (ua.man != '0);
    b_nan  = (ub.exp == EXP_MAX) && (ub.man != '0);
    a_inf  = (ua.exp == EXP_MAX) && (ua.man == '0);
    b_inf  = (ub.exp == EXP_MAX) && (ub.man == '0);
    a_zero = (ua.exp == '0);
    b_zero = (ub.exp == '0);

    // x carries the larger magnitude so the aligned difference never goes negative
    swap = {ub.exp, b_zero ? 23'd0 : ub.man} > {ua.exp, a_zero ? 23'd0 : ua.man};
    x    = swap ? ub : ua;
    z    = swap ? ua : ub;
    sub  = x.sign ^ z.sign;

    mx = (x.exp == '0) ? '0 : {1'b1, x.man, 3'b000};
    mz = (z.exp == '0) ? '0 : {1'b1, z.man, 3'b000};
    d  = x.exp - z.exp;
    dc = (d > 8'd27) ? 5'd27 : d[4:0];
    sh = {mz, 27'd0} >> dc;
    ms = {sh[53:28], sh[27] | (|sh[26:0])};

    sum = sub ? ({1'b0, mx} - {1'b0, ms}) : ({1'b0, mx} + {1'b0, ms});

    lz = '0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);

    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e   = $signed({2'b00, x.exp}) + 10'sd1;
    end else begin
      nrm = sum[26:0] << lz;
      e   = $signed({2'b00, x.exp}) - $signed({5'd0, lz});
    end

    rnd = {1'b0, nrm[25:3]} + {23'd0, nrm[2] & (nrm[3] | nrm[1] | nrm[0])};
    if (rnd[23]) e = e + 10'sd1;

    if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign))) y = QNAN;
    else if (a_inf)              y = a;
    else if (b_inf)              y = b;
    else if (!nrm[26])           y = {a_zero & b_zero & ua.sign & ub.sign, 31'd0};
    else if (e >= 10'sd255)      y = {x.sign, EXP_MAX, 23'd0};
    else if (e <= 10'sd0)        y = {x.sign, 31'd0};
    else                         y = {x.sign, e[7:0], rnd[22:0]};
  end
endmodule

// File: rtl/fp_accum_tree.sv
// N-lane registered binary32 adder tree feeding a packet accumulator with backpressure.
module fp_accum_tree
  import fp_pkg::*;
#(
  parameter int N = 8
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*FW-1:0] in_data,
  input  logic            in_last,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FW-1:0]   out_data
);
  localparam int LVLS = $clog2(N);

  logic            adv, acc_first, pkt_end;
  logic [LVLS:1]   vld_pipe, mode_pipe, last_pipe;
  logic [FW-1:0]   acc, acc_sum, acc_next, tree_sum;

  // the whole pipe freezes while a result waits for the consumer
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int W = N >> l;
    logic [W-1:0][FW-1:0] q, s;

    for (genvar k = 0; k < W; k++) begin : g_pair
      logic [FW-1:0] a, b;
      if (l == 1) begin : g_src
        assign a = in_data[(2*k)*FW +: FW];
        assign b = in_data[(2*k+1)*FW +: FW];
      end else begin : g_src
        assign a = g_lvl[l-1].q[2*k];
        assign b = g_lvl[l-1].q[2*k+1];
      end
      fp_add u_add (.a(a), .b(b), .y(s[k]));
    end

    always_ff @(posedge clk) begin
      if (rst)      q <= '0;
      else if (adv) q <= s;
    end

    if (l == LVLS) begin : g_root
      assign tree_sum = q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      last_pipe <= '0;
    end else if (adv) begin
      for (int i = LVLS; i > 1; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        mode_pipe[i] <= mode_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      vld_pipe[1]  <= in_valid;
      mode_pipe[1] <= in_mode;
      last_pipe[1] <= in_last;
    end
  end

  fp_add u_acc_add (.a(acc), .b(tree_sum), .y(acc_sum));

  // first beat loads directly so a -0 tree sum is not turned into +0
  assign acc_next = acc_first ? tree_sum : acc_sum;
  assign pkt_end  = !mode_pipe[LVLS] || last_pipe[LVLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_first <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= vld_pipe[LVLS] && pkt_end;
      if (vld_pipe[LVLS]) begin
        acc       <= acc_next;
        acc_first <= pkt_end;
        if (pkt_end) out_data <= acc_next;
      end
    end
  end
endmodule

// File: tb/tb_fp_accum_tree.sv
// Randomised and directed checks of fp_accum_tree against a real-arithmetic reference model.
module tb_fp_accum_tree;
  localparam int N = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  logic            clk = 0, rst = 1, in_valid = 0, in_last = 0, in_mode = 0, out_ready = 1;
  logic            in_ready, out_valid;
  logic [N*32-1:0] in_data = '0;
  logic [31:0]     out_data;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q [$];
  logic [31:0] lanes [N];
  bit          m_first = 1;
  logic [31:0] m_acc = '0;
  int          ready_mode = 0, stall_left = 0, stall_seen = 0;
  bit          stall_done = 0;

  fp_accum_tree #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %08h want %08h", name, act, want);
  endtask

  // ---------------- reference model: exact real sum, then RNE to binary32 ----------------
  function automatic real f2r(input logic [31:0] f);
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    return $bitstoreal({f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          fe;
    logic [24:0] q;
    logic [28:0] rem;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    fe  = int'(d[62:52]) - 1023 + 127;
    q   = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && q[0])) q = q + 25'd1;
    if (q[24]) begin q = q >> 1; fe++; end
    if (fe >= 255) return {d[63], 8'hFF, 23'd0};
    if (fe <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(fe), q[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    bit an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bit bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    bit ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bit bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (an || bn) return QNAN;
    if (ai && bi) return (a[31] != b[31]) ? QNAN : a;
    if (ai) return a;
    if (bi) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic model_beat(input bit mode, input bit last, input bit use_want, input logic [31:0] want);
    logic [31:0] v [N];
    logic [31:0] acc;
    bit          endp;
    for (int i = 0; i < N; i++) v[i] = lanes[i];
    for (int w = N; w > 1; w = w / 2)
      for (int k = 0; k < w / 2; k++) v[k] = ref_add(v[2*k], v[2*k+1]);
    acc     = m_first ? v[0] : ref_add(m_acc, v[0]);
    m_acc   = acc;
    endp    = !mode || last;
    m_first = endp;
    if (endp) exp_q.push_back(use_want ? want : acc);
  endtask

  // ---------------- driver helpers ----------------
  task automatic send(input bit mode, input bit last, input bit use_want, input logic [31:0] want);
    for (int i = 0; i < N; i++) in_data[i*32 +: 32] = lanes[i];
    in_mode = mode; in_last = last; in_valid = 1;
    for (int w = 0; ; w++) begin
      @(negedge clk);
      if (in_ready) break;
      if (w == 500) begin
        $display("FAIL accept_timeout: in_ready stuck at 0, want 1");
        $fatal(1, "beat never accepted");
      end
      @(posedge clk); #1;
    end
    model_beat(mode, last, use_want, want);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < N; i++) lanes[i] = v;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); m_first = 1; m_acc = '0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 1000) begin @(posedge clk); w++; end
    @(posedge clk); #1;
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd_f();
    int          c = $urandom_range(0, 99);
    logic        s = 1'($urandom_range(0, 1));
    logic [22:0] m = 23'($urandom);
    if (c < 55) return {s, 8'(118 + $urandom_range(0, 16)), m};
    if (c < 67) return {s, 8'd0, m};
    if (c < 77) return {s, 8'($urandom_range(1, 3)), m};
    if (c < 87) return {s, 8'($urandom_range(250, 254)), m};
    if (c < 89) return {s, 8'hFF, 23'd0};
    if (c < 90) return {s, 8'hFF, m | 23'd1};
    return 32'($urandom);
  endfunction

  // ---------------- consumer and monitor ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: if (stall_left > 0) begin out_ready = 0; stall_left--; end
         else if (!stall_done && out_valid) begin out_ready = 0; stall_left = 2; stall_done = 1; end
         else out_ready = 1;
      default: out_ready = 1;
    endcase
  end

  bit          prev_stall = 0;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_data_held", out_data, prev_data);
      end
      if (out_valid && !out_ready && !in_ready) stall_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got %08h want no output", out_data);
        end else chk("result", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else prev_stall = 0;
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, beats;
    bit mode;
    int len;

    do_reset();

    // single mode-0 beat of 1.0s with latency measurement
    fill(ONE);
    send(0, 0, 1, 32'h4100_0000);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd4);
    drain();

    // three-beat packet
    fill(ONE);
    send(1, 0, 1, 32'h0);
    send(1, 0, 1, 32'h0);
    send(1, 1, 1, 32'h41C0_0000);
    drain();

    // specials and boundaries, mode 0
    fill(32'h0); lanes[0] = 32'h7F80_0000; lanes[1] = 32'hFF80_0000;
    send(0, 1, 1, QNAN);
    fill(32'h0); lanes[0] = 32'h7F80_0000;
    send(0, 0, 1, 32'h7F80_0000);
    fill(32'h7F7F_FFFF);
    send(0, 0, 1, 32'h7F80_0000);
    fill(32'hFF7F_FFFF);
    send(0, 0, 1, 32'hFF80_0000);
    for (int i = 0; i < N; i++) lanes[i] = (i % 2) ? 32'hC0A0_0000 : 32'h40A0_0000;
    send(0, 0, 1, 32'h0000_0000);
    fill(32'h8000_0000);
    send(0, 0, 1, 32'h8000_0000);
    fill(32'h0000_0001);
    send(0, 0, 1, 32'h0000_0000);
    fill(32'h0); lanes[3] = 32'h7FC1_2345;
    send(0, 0, 1, QNAN);
    // 1.0 + 2^-24 ties to even (stays 1.0), 1.0+ulp plus half ulp rounds up
    fill(32'h0); lanes[0] = ONE; lanes[1] = 32'h3380_0000;
    send(0, 0, 1, ONE);
    fill(32'h0); lanes[0] = 32'h3F80_0001; lanes[1] = 32'h3380_0000;
    send(0, 0, 1, 32'h3F80_0002);
    drain();

    // back-to-back beats with a 3-cycle consumer stall
    stall_seen = 0; stall_done = 0; ready_mode = 2;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < N; i++) lanes[i] = rnd_f();
      send(0, 0, 0, 32'h0);
    end
    drain();
    chk("stall_cycles", 32'(stall_seen), 32'd3);
    ready_mode = 0;

    // reset in the middle of a packet
    fill(ONE);
    send(1, 0, 1, 32'h0);
    send(1, 0, 1, 32'h0);
    do_reset();
    fill(ONE);
    send(0, 1, 1, 32'h4100_0000);
    drain();

    // randomised packets with bubbles and random backpressure
    ready_mode = 1;
    beats = 0;
    while (beats < 10000) begin
      mode = 1'($urandom_range(0, 1));
      len  = mode ? $urandom_range(1, 5) : 1;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        for (int i = 0; i < N; i++) lanes[i] = rnd_f();
        send(mode, mode ? (b == len - 1) : 1'($urandom_range(0, 1)), 0, 32'h0);
        beats++;
      end
    end
    drain();
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_accum_tree.md
FP_ACCUM_TREE -- requirements
Module: fp_accum_tree

Interface
REQ-001 Parameter N, default 8: lane count; SHALL be a power of two, >= 2.
REQ-002 Parameter EW/MW fixed by package: IEEE-754 binary32 (1/8/23); no width parameter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  input beat present.
REQ-006 in_ready  out  1  block can accept a beat this cycle.
REQ-007 in_data  in  N x 32  one binary32 operand per lane.
REQ-008 in_last  in  1  final beat of a packet (accumulate mode).
REQ-009 in_mode  in  1  0 = per-beat sum, 1 = accumulate across beats until in_last.
REQ-010 out_valid  out  1  out_data holds a completed sum.
REQ-011 out_ready  in  1  consumer accepts out_data.
REQ-012 out_data  out  32  binary32 result.

Function
REQ-013 Beat accepted when in_valid && in_ready; in_data, in_last, in_mode captured together.
REQ-014 Reduction tree: log2(N) levels, pairwise adds lane 2k + lane 2k+1, each level registered with its own valid bit and mode/last sideband.
REQ-015 Accumulate stage after tree: one register acc; first beat of packet loads acc = tree_sum, later beats acc = acc + tree_sum.
REQ-016 Latency: beat accepted in cycle t produces out_valid in cycle t + log2(N) + 1 (N=8: 4 cycles) absent stalls.
REQ-017 Mode 0: every beat is first and last; out_valid for every accepted beat; in_last ignored.
REQ-018 Mode 1: out_valid only for beat with in_last=1; intermediate beats update acc silently.
REQ-019 First-of-packet flag set by reset and after each last beat leaves the accumulate stage; mode switching between packets SHALL be legal, within a packet undefined.
REQ-020 Throughput: one beat per cycle with out_ready held high.
REQ-021 Stall: when out_valid && !out_ready, all pipeline and acc registers hold, in_ready = 0, out_data stable.
REQ-022 in_ready = !(out_valid && !out_ready); combinational, no dependence on in_valid.
REQ-023 Bubbles (invalid stage entries) SHALL NOT modify acc or first-of-packet flag.
REQ-024 Arithmetic: round-to-nearest-even; subnormal inputs and results flushed to signed zero.
REQ-025 Specials: any NaN operand or +Inf + -Inf -> canonical 0x7FC00000; Inf + finite -> that Inf; overflow -> correctly signed Inf; x + (-x) -> +0.
REQ-026 Summation order fixed (tree order, then acc); results bit-exact to a reference model using the same order.

Reset
REQ-027 In the cycle after rst=1: out_valid=0, out_data=0x00000000, all stage valids 0, acc=0, first-of-packet=1, in_ready=1.
REQ-028 rst during a packet discards all in-flight beats and partial acc; no out_valid for that packet.
REQ-029 rst overrides in_valid and out_ready in the same cycle.

Structure
REQ-030 Package fp_pkg: binary32 field widths, bias 127, QNAN constant 0x7FC00000, struct/typedef for unpacked sign/exp/mant.
REQ-031 Sub-module fp_add: combinational binary32 adder per REQ-024/025, instantiated N-1 times in tree plus once in accumulate stage.
REQ-032 Tree generated by loops from N; no per-N hand code.

Verification
REQ-033 N=8, mode 0, all lanes 0x3F800000 (1.0), one beat -> out_valid cycle t+4, out_data 0x41000000 (8.0).
REQ-034 N=8, mode 1, three consecutive beats all 1.0, last on third -> single out_valid, out_data 0x41C00000 (24.0); no earlier out_valid.
REQ-035 Lane0 0x7F800000, lane1 0xFF800000, rest 0 -> out_data 0x7FC00000; lane0 0x7F800000 alone -> 0x7F800000.
REQ-036 Back-to-back mode-0 beats, out_ready low 3 cycles at first out_valid -> in_ready 0, out_data held, all results later delivered in order, none lost or duplicated.
REQ-037 Mode 1, rst asserted after beat 2 of 4 -> no output for that packet; next single-beat mode-0 packet of 1.0s -> 0x41000000.
REQ-038 Randomised lanes incl. subnormals and mixed signs vs ordered reference model, 10k beats, bit-exact.
